// File: rtl/idct_pkg.sv
// Shared helpers for the IDCT butterfly datapath: output width derivation,
// saturation bounds for a given width and lane slice positioning.
package idct_pkg;

   function automatic int out_width(input int data_w, input int sat);
      return (sat != 0) ? data_w : data_w + 1;
   endfunction

   function automatic longint sat_max(input int width);
      return (longint'(1) <<< (width - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

   // Lanes are packed LSB-first, so lane i starts at bit i*width.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/idct_bfly_lane.sv
// Single-lane butterfly: a+b and a-b at DATA_W+1 precision, optionally
// clamped back to DATA_W with a flag when either result was clamped.
module idct_bfly_lane
   import idct_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int SAT    = 0,
   localparam int OUT_W = out_width(DATA_W, SAT)
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [OUT_W-1:0]  sum,
   output logic signed [OUT_W-1:0]  dif,
   output logic                     clamped
);

   logic signed [DATA_W:0] sum_full;
   logic signed [DATA_W:0] dif_full;

   assign sum_full = {a[DATA_W-1], a} + {b[DATA_W-1], b};
   assign dif_full = {a[DATA_W-1], a} - {b[DATA_W-1], b};

   if (SAT != 0) begin : g_sat
      localparam logic signed [DATA_W:0] MAX_V = (DATA_W + 1)'(sat_max(DATA_W));
      localparam logic signed [DATA_W:0] MIN_V = (DATA_W + 1)'(sat_min(DATA_W));

      logic sum_clamp;
      logic dif_clamp;

      always_comb begin
         sum       = sum_full[OUT_W-1:0];
         sum_clamp = 1'b0;
         if (sum_full > MAX_V) begin
            sum       = MAX_V[OUT_W-1:0];
            sum_clamp = 1'b1;
         end else if (sum_full < MIN_V) begin
            sum       = MIN_V[OUT_W-1:0];
            sum_clamp = 1'b1;
         end
      end

      always_comb begin
         dif       = dif_full[OUT_W-1:0];
         dif_clamp = 1'b0;
         if (dif_full > MAX_V) begin
            dif       = MAX_V[OUT_W-1:0];
            dif_clamp = 1'b1;
         end else if (dif_full < MIN_V) begin
            dif       = MIN_V[OUT_W-1:0];
            dif_clamp = 1'b1;
         end
      end

      assign clamped = sum_clamp | dif_clamp;
   end else begin : g_full
      assign sum     = sum_full;
      assign dif     = dif_full;
      assign clamped = 1'b0;
   end

endmodule

// File: rtl/idct_butterfly_pipe.sv
// Pipelined N-lane butterfly stage with valid/ready flow control, a block
// row counter on the output side and a sticky saturation flag.
module idct_butterfly_pipe
   import idct_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int N_LANES     = 4,
   parameter int PIPE_STAGES = 2,
   parameter int SAT         = 0,
   parameter int BLOCK_ROWS  = 8,
   localparam int OUT_W      = out_width(DATA_W, SAT),
   localparam int ROW_W      = $clog2(BLOCK_ROWS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N_LANES*DATA_W-1:0]  in_a,
   input  logic [N_LANES*DATA_W-1:0]  in_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_LANES*OUT_W-1:0]   out_sum,
   output logic [N_LANES*OUT_W-1:0]   out_dif,
   output logic [ROW_W-1:0]           out_row,
   output logic                       out_last,
   output logic                       sat_flag,
   input  logic                       sat_clr
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BLOCK_ROWS - 1);

   logic [N_LANES*OUT_W-1:0] comb_sum;
   logic [N_LANES*OUT_W-1:0] comb_dif;
   logic [N_LANES-1:0]       lane_clamp;

   logic [PIPE_STAGES-1:0]   valid_q;
   logic [PIPE_STAGES-1:0]   ready;
   logic [N_LANES*OUT_W-1:0] sum_q [PIPE_STAGES];
   logic [N_LANES*OUT_W-1:0] dif_q [PIPE_STAGES];
   logic                     in_hs;
   logic                     out_hs;

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      idct_bfly_lane #(
         .DATA_W (DATA_W),
         .SAT    (SAT)
      ) u_lane (
         .a       (in_a[lane_lsb(i, DATA_W) +: DATA_W]),
         .b       (in_b[lane_lsb(i, DATA_W) +: DATA_W]),
         .sum     (comb_sum[lane_lsb(i, OUT_W) +: OUT_W]),
         .dif     (comb_dif[lane_lsb(i, OUT_W) +: OUT_W]),
         .clamped (lane_clamp[i])
      );
   end

   // Unrolled form of ready_k = !valid_k || ready_{k+1}: stage k can load
   // unless it and every stage downstream of it is full and out_ready is low.
   for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_ready
      assign ready[k] = out_ready || !(&valid_q[PIPE_STAGES-1:k]);
   end

   assign in_ready  = ready[0];
   assign in_hs     = in_valid && ready[0];
   assign out_valid = valid_q[PIPE_STAGES-1];
   assign out_hs    = out_valid && out_ready;
   assign out_sum   = sum_q[PIPE_STAGES-1];
   assign out_dif   = dif_q[PIPE_STAGES-1];
   assign out_last  = out_valid && (out_row == LAST_ROW);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            valid_q[k] <= 1'b0;
            sum_q[k]   <= '0;
            dif_q[k]   <= '0;
         end
      end else begin
         if (ready[0]) begin
            valid_q[0] <= in_valid;
            sum_q[0]   <= comb_sum;
            dif_q[0]   <= comb_dif;
         end
         for (int k = 1; k < PIPE_STAGES; k++) begin
            if (ready[k]) begin
               valid_q[k] <= valid_q[k-1];
               sum_q[k]   <= sum_q[k-1];
               dif_q[k]   <= dif_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_row <= '0;
      end else if (out_hs) begin
         out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
      end
   end

   // A clamp on the accepted beat takes priority over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_flag <= 1'b0;
      end else if ((SAT != 0) && in_hs && (|lane_clamp)) begin
         sat_flag <= 1'b1;
      end else if (sat_clr) begin
         sat_flag <= 1'b0;
      end
   end

endmodule
